// File: rtl/sn74ls11_tester.sv
// Self-test sequencer for a triple 3-input AND package: walks all 8 vectors through the three
// gates and reports pass/fail. Optional abort input enabled by SN74LS11_TESTER_ABORT_EN.
module sn74ls11_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_start,
`ifdef SN74LS11_TESTER_ABORT_EN
  input  logic       in_abort,
  output logic       out_aborted,
`endif
  input  logic [2:0] in_gate_out,
  output logic [8:0] out_gate_in,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_pass,
  output logic [2:0] out_fail_mask,
  output logic [2:0] out_first_fail_vec
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] gate_in_q, gate_in_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] mask_q, mask_d;
  logic [2:0] ffv_q, ffv_d;
  logic       expected;
  logic [2:0] mismatch;
`ifdef SN74LS11_TESTER_ABORT_EN
  logic       aborted_q, aborted_d;
`endif

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    gate_in_d = gate_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    mask_d    = mask_q;
    ffv_d     = ffv_q;
    expected  = &vec_q;
    mismatch  = in_gate_out ^ {3{expected}};
`ifdef SN74LS11_TESTER_ABORT_EN
    aborted_d = aborted_q;
`endif

    unique case (state_q)
      StIdle: begin
        gate_in_d = '0;
        if (in_start) begin
          vec_d     = '0;
          cnt_d     = '0;
          pass_d    = 1'b0;
          mask_d    = '0;
          ffv_d     = '0;
          busy_d    = 1'b1;
          state_d   = StSettle;
`ifdef SN74LS11_TESTER_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CntLast) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        mask_d = mask_q | mismatch;
        // First failing vector is latched only while no earlier mismatch exists.
        if ((mismatch != 3'b000) && (mask_q == 3'b000)) begin
          ffv_d = vec_q;
        end
        if (vec_q == 3'd7) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = ((mask_q | mismatch) == 3'b000);
        end else begin
          vec_d     = vec_q + 3'd1;
          gate_in_d = {3{vec_q + 3'd1}};
          cnt_d     = '0;
          state_d   = StSettle;
        end
      end
      StDone: begin
        gate_in_d = '0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef SN74LS11_TESTER_ABORT_EN
    // Abort overrides everything in the active phases, including the final check.
    if (in_abort && ((state_q == StSettle) || (state_q == StCheck))) begin
      state_d   = StIdle;
      vec_d     = vec_q;
      cnt_d     = cnt_q;
      gate_in_d = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      mask_d    = mask_q;
      ffv_d     = ffv_q;
      aborted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      vec_q     <= '0;
      cnt_q     <= '0;
      gate_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      mask_q    <= '0;
      ffv_q     <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      gate_in_q <= gate_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      mask_q    <= mask_d;
      ffv_q     <= ffv_d;
    end
  end

`ifdef SN74LS11_TESTER_ABORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign out_aborted = aborted_q;
`endif

  assign out_gate_in        = gate_in_q;
  assign out_busy           = busy_q;
  assign out_done           = done_q;
  assign out_pass           = pass_q;
  assign out_fail_mask      = mask_q;
  assign out_first_fail_vec = ffv_q;

endmodule

// File: tb/tb_sn74ls11_tester.sv
// Bench for sn74ls11_tester: faulty/healthy gate package model, cycle-level reference model,
// scripted scenarios plus randomized starts, resets and gate faults.
module tb_sn74ls11_tester;

  localparam int S     = 2;
  localparam int P     = S + 1;
  localparam int DoneT = 8 * P + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_start = 1'b0;
  logic [2:0] in_gate_out = '0;
  logic [8:0] out_gate_in;
  logic       out_busy;
  logic       out_done;
  logic       out_pass;
  logic [2:0] out_fail_mask;
  logic [2:0] out_first_fail_vec;
`ifdef SN74LS11_TESTER_ABORT_EN
  logic       in_abort = 1'b0;
  logic       out_aborted;
`endif

  always #5 clk = ~clk;

  sn74ls11_tester #(
    .SETTLE_CYCLES(S)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_start          (in_start),
`ifdef SN74LS11_TESTER_ABORT_EN
    .in_abort          (in_abort),
    .out_aborted       (out_aborted),
`endif
    .in_gate_out       (in_gate_out),
    .out_gate_in       (out_gate_in),
    .out_busy          (out_busy),
    .out_done          (out_done),
    .out_pass          (out_pass),
    .out_fail_mask     (out_fail_mask),
    .out_first_fail_vec(out_first_fail_vec)
  );

  int n_vec = 0;
  int n_err = 0;

  // Per gate: 0 healthy, 1 stuck-at-0, 2 stuck-at-1 (2 bits each, gate 1 in [1:0]).
  logic [5:0] cfg = '0;
  bit         cmp_en = 1'b0;

  // Reference model: position in the run counted in cycles since the accept edge.
  bit         m_run = 1'b0;
  int         m_t = 0;
  logic [2:0] m_mask = '0;
  logic [2:0] m_ffv = '0;
  logic       m_pass = 1'b0;
  logic       m_aborted = 1'b0;
  logic [5:0] m_cfg = '0;

  function automatic logic [2:0] dev(input logic [5:0] c, input logic [8:0] gin);
    logic [2:0] y;
    y = '0;
    for (int g = 0; g < 3; g++) begin
      case (c[2*g +: 2])
        2'd1:    y[g] = 1'b0;
        2'd2:    y[g] = 1'b1;
        default: y[g] = &gin[3*g +: 3];
      endcase
    end
    return y;
  endfunction

  function automatic logic [2:0] mism(input logic [5:0] c, input logic [2:0] v);
    return dev(c, {v, v, v}) ^ {3{&v}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model advance.
  initial begin
    logic [2:0] mm;
    logic [2:0] v;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 1'b0; m_t = 0; m_mask = '0; m_ffv = '0; m_pass = 1'b0; m_aborted = 1'b0;
      end else if (!m_run) begin
        if (in_start) begin
          m_run = 1'b1; m_t = 1; m_mask = '0; m_ffv = '0; m_pass = 1'b0; m_aborted = 1'b0;
          m_cfg = cfg;
        end
`ifdef SN74LS11_TESTER_ABORT_EN
      end else if (in_abort && (m_t <= 8 * P)) begin
        m_run = 1'b0; m_aborted = 1'b1; m_pass = 1'b0;
`endif
      end else if (m_t == DoneT) begin
        m_run = 1'b0;
      end else begin
        if (m_t % P == 0) begin
          v  = 3'(m_t / P - 1);
          mm = mism(m_cfg, v);
          if ((mm != 3'b000) && (m_mask == 3'b000)) m_ffv = v;
          m_mask = m_mask | mm;
          if (m_t == 8 * P) m_pass = (m_mask == 3'b000);
        end
        m_t++;
      end
    end
  end

  // Gate package: real response only in check cycles, noise otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (m_run && (m_t >= P) && (m_t <= 8 * P) && (m_t % P == 0))
        in_gate_out = dev(cfg, out_gate_in);
      else
        in_gate_out = 3'($urandom);
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    int         vi;
    logic [2:0] v3;
    forever begin
      @(negedge clk);
      if (cmp_en && rst_n) begin
        vi = (m_t - 1) / P;
        if (vi > 7) vi = 7;
        v3 = 3'(vi);
        chk("gate_in", 32'(out_gate_in), m_run ? 32'({v3, v3, v3}) : 32'(0));
        chk("busy", 32'(out_busy), 32'(m_run && (m_t <= 8 * P)));
        chk("done", 32'(out_done), 32'(m_run && (m_t == DoneT)));
        chk("pass", 32'(out_pass), 32'(m_pass));
        chk("fail_mask", 32'(out_fail_mask), 32'(m_mask));
        chk("first_fail_vec", 32'(out_first_fail_vec), 32'(m_ffv));
`ifdef SN74LS11_TESTER_ABORT_EN
        chk("aborted", 32'(out_aborted), 32'(m_aborted));
`endif
      end
    end
  end

  task automatic watch_run(input int extra_a, input int extra_b, input int window,
                           output int first_done, output int n_done);
    @(negedge clk);
    in_start   = 1'b1;
    first_done = -1;
    n_done     = 0;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (out_done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      in_start = (k == extra_a) || (k == extra_b);
    end
    in_start = 1'b0;
  endtask

  task automatic chk_results(input string nm, input logic p, input logic [2:0] m,
                             input logic [2:0] f);
    chk({nm, "_pass"}, 32'(out_pass), 32'(p));
    chk({nm, "_mask"}, 32'(out_fail_mask), 32'(m));
    chk({nm, "_ffv"}, 32'(out_first_fail_vec), 32'(f));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gate_in"}, 32'(out_gate_in), 32'(0));
    chk({nm, "_busy"}, 32'(out_busy), 32'(0));
    chk({nm, "_done"}, 32'(out_done), 32'(0));
    chk_results(nm, 1'b0, 3'b000, 3'b000);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int fd, nd;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Healthy package, extra starts at cycles 5 and 25 must be ignored.
    cfg = 6'b00_00_00;
    watch_run(5, 25, 26, fd, nd);
    chk("healthy_done_cycle", 32'(fd), 32'(25));
    chk("healthy_done_count", 32'(nd), 32'(1));
    chk_results("healthy", 1'b1, 3'b000, 3'b000);

    // Restart at cycle 27: done at 52.
    watch_run(-1, -1, 28, fd, nd);
    chk("restart_done_cycle", 32'(27 + fd), 32'(52));
    chk("restart_done_count", 32'(nd), 32'(1));
    chk_results("restart", 1'b1, 3'b000, 3'b000);

    cfg = 6'b00_10_00;
    watch_run(-1, -1, 28, fd, nd);
    chk("g2s1_done_cycle", 32'(fd), 32'(25));
    chk_results("g2s1", 1'b0, 3'b010, 3'b000);

    cfg = 6'b01_00_00;
    watch_run(-1, -1, 28, fd, nd);
    chk_results("g3s0", 1'b0, 3'b100, 3'b111);

    cfg = 6'b01_00_10;
    watch_run(-1, -1, 28, fd, nd);
    chk_results("g1s1g3s0", 1'b0, 3'b101, 3'b000);

    // Reset at cycle 10 of a faulty run: everything clears at once, no done pulse.
    cfg = 6'b00_10_00;
    @(negedge clk);
    in_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_start = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cfg   = 6'b00_00_00;
    nd    = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_done === 1'b1) nd++;
    end
    chk("midreset_no_done", 32'(nd), 32'(0));
    watch_run(-1, -1, 28, fd, nd);
    chk("after_reset_done_cycle", 32'(fd), 32'(25));
    chk_results("after_reset", 1'b1, 3'b000, 3'b000);

`ifdef SN74LS11_TESTER_ABORT_EN
    @(negedge clk);
    in_start = 1'b1;
    nd = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      in_start = 1'b0;
    end
    in_abort = 1'b1;
    @(negedge clk);
    in_abort = 1'b0;
    chk("abort_busy", 32'(out_busy), 32'(0));
    chk("abort_flag", 32'(out_aborted), 32'(1));
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_done === 1'b1) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'(0));
    watch_run(-1, -1, 28, fd, nd);
    chk("abort_cleared", 32'(out_aborted), 32'(0));
    chk("post_abort_done_cycle", 32'(fd), 32'(25));
`endif

    // Randomized phase: random faults, start pulses, occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!m_run) begin
        for (int g = 0; g < 3; g++) begin
          case ($urandom % 4)
            2:       cfg[2*g +: 2] = 2'd1;
            3:       cfg[2*g +: 2] = 2'd2;
            default: cfg[2*g +: 2] = 2'd0;
          endcase
        end
      end
      in_start = ($urandom % 8 == 0);
`ifdef SN74LS11_TESTER_ABORT_EN
      in_abort = ($urandom % 60 == 0);
`endif
      if ($urandom % 300 == 0) begin
        in_start = 1'b0;
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    in_start = 1'b0;
`ifdef SN74LS11_TESTER_ABORT_EN
    in_abort = 1'b0;
`endif
    repeat (30) @(negedge clk);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sn74ls11_tester.md
Name: sn74ls11_tester

Overview:
Self-test sequencer for the triple 3-input AND package (three AND3X1 gates).
- On a start pulse it walks all 8 input vectors through the three gates in parallel, waits a settle interval, and compares each gate output with the AND of the vector.
- Reports pass/fail, a per-gate fail mask and the first failing vector.
- Sits beside the gate package in the lab bench top level and drives its nine inputs in place of switches.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15; counter width 4.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_start  input  1  start request; accepted only in IDLE
in_gate_out  input  3  gate outputs; bit0 = gate 1 Y, bit1 = gate 2 Y, bit2 = gate 3 Y
out_gate_in  output  9  gate inputs; [2:0] gate 1 inputs 1..3, [5:3] gate 2, [8:6] gate 3
out_busy  output  1  high while a test is running
out_done  output  1  one-cycle pulse when results are valid
out_pass  output  1  1 = no mismatch in last completed test
out_fail_mask  output  3  bit g set = gate g+1 mismatched on some vector
out_first_fail_vec  output  3  vector of first mismatch; 0 when pass

Behaviour:
- One clock; reset asynchronous, active-low.
- All outputs are registered.
- States: IDLE, SETTLE, CHECK, DONE.
- Internal registers: vec[2:0], cnt[3:0], result registers.
- Reset (rst_n=0, immediate, asynchronous):
  - state=IDLE, vec=0, cnt=0.
  - out_gate_in=0, out_busy=0, out_done=0, out_pass=0, out_fail_mask=0, out_first_fail_vec=0.
- IDLE:
  - out_gate_in=0.
  - If in_start=1: vec<=0, cnt<=0, out_gate_in<={3{3'b000}}, clear out_pass/out_fail_mask/out_first_fail_vec, out_busy<=1, go to SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to CHECK.
- CHECK:
  - expected = &vec.
  - mismatch[g] = in_gate_out[g] ^ expected.
  - fail_mask |= mismatch.
  - On the first nonzero mismatch of the run, first_fail_vec <= vec.
  - If vec==7: go to DONE.
  - Otherwise: vec<=vec+1, out_gate_in<={vec+1, vec+1, vec+1}, cnt<=0, go to SETTLE.
- DONE (one cycle):
  - out_done=1, out_busy=0, out_pass = (fail_mask==0); results are visible this cycle.
  - out_gate_in<=0, go to IDLE.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. out_done is asserted 8*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge (25 for default).
- Result outputs hold until the next accepted start.
- in_start while busy or in DONE: ignored; it is not queued.
- in_gate_out is sampled only in CHECK; X/glitches during SETTLE are don't-care.
- Reset mid-test: abandon immediately, no out_done pulse, results cleared.

Optional Feature:
Macro SN74LS11_TESTER_ABORT_EN.
- Defined:
  - Adds in_abort (input, 1) and out_aborted (output, 1).
  - in_abort=1 in SETTLE or CHECK: next edge goes to IDLE, out_gate_in<=0, out_busy<=0, out_aborted<=1, no out_done pulse, out_pass=0.
  - out_aborted clears on the next accepted start or on reset.
  - in_abort in IDLE/DONE is ignored.
  - If in_abort and the vec==7 CHECK coincide, abort wins.
- Undefined: ports absent; the test always runs to completion.

Test Plan:
- Three healthy AND3X1 models, SETTLE_CYCLES=2, start pulse at cycle 0
  -> out_gate_in steps 000000000, 001001001 ... 111111111, each held 3 cycles
  -> out_done at cycle 25; out_pass=1, out_fail_mask=000, out_first_fail_vec=0.
- Gate 2 output stuck-at-1
  -> out_pass=0, out_fail_mask=010, out_first_fail_vec=000.
- Gate 3 output stuck-at-0
  -> out_pass=0, out_fail_mask=100, out_first_fail_vec=111.
- Gate 1 output stuck-at-1 and gate 3 output stuck-at-0
  -> out_fail_mask=101, out_first_fail_vec=000.
- Extra in_start pulses at cycles 5 and 25
  -> only one out_done, at cycle 25.
- Start again at cycle 27
  -> results clear, a new run completes, out_done at cycle 52.
- rst_n low at cycle 10 for 2 cycles
  -> all outputs 0 immediately, no out_done; a following start completes normally.
- ABORT_EN: in_abort at cycle 8
  -> IDLE at cycle 9, out_aborted=1, out_busy=0, no out_done; a next start clears out_aborted.
